// File: rtl/multichannel_shift_bank.sv
// Parametrised bank of serial-entry shift channels. Pin strobes are synchronised
// and edge-detected. The bank supports shift, rotate, cascaded chain, clear and snapshot capture.
module multichannel_shift_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      shift_strb,
  input  logic                      cap_strb,
  input  logic [1:0]                mode,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  input  logic [$clog2(NUM_CH)-1:0] rd_sel,
  input  logic                      ser_in,
  input  logic                      out_en,
  output logic [WIDTH-1:0]          par_out,
  output logic                      ser_out,
  output logic                      rd_full
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned FILL_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_CHAIN  = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  logic [SYNC_STAGES-1:0] shift_sync_q;
  logic [SYNC_STAGES-1:0] cap_sync_q;
  logic                   shift_hist_q;
  logic                   cap_hist_q;
  logic [WIDTH-1:0]       ch_q   [NUM_CH];
  logic [WIDTH-1:0]       ch_d   [NUM_CH];
  logic [FILL_W-1:0]      fill_q [NUM_CH];
  logic [FILL_W-1:0]      fill_d [NUM_CH];
  logic [WIDTH-1:0]       snap_q;
  logic [WIDTH-1:0]       snap_d;

  logic shift_pulse;
  logic cap_pulse;
  logic ch_valid;
  logic rd_valid;

  function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_W'(WIDTH)) ? f : f + FILL_W'(1);
  endfunction

  assign shift_pulse = shift_sync_q[SYNC_STAGES-1] & ~shift_hist_q;
  assign cap_pulse   = cap_sync_q[SYNC_STAGES-1] & ~cap_hist_q;
  // Selects beyond NUM_CH only exist when NUM_CH is not a power of two.
  assign ch_valid    = ({1'b0, ch_sel} < (CH_W + 1)'(NUM_CH));
  assign rd_valid    = ({1'b0, rd_sel} < (CH_W + 1)'(NUM_CH));

  // Next-state for channels, fill counters and snapshot.
  always_comb begin
    ch_d   = ch_q;
    fill_d = fill_q;
    snap_d = snap_q;
    // Snapshot reads pre-update channel state, so a same-edge shift is not seen.
    if (cap_pulse && ena) begin
      snap_d = rd_valid ? ch_q[rd_sel] : '0;
    end
    if (shift_pulse && ena) begin
      case (mode_e'(mode))
        MODE_SHIFT: begin
          if (ch_valid) begin
            ch_d[ch_sel]   = {ch_q[ch_sel][WIDTH-2:0], ser_in};
            fill_d[ch_sel] = sat_inc(fill_q[ch_sel]);
          end
        end
        MODE_ROTATE: begin
          if (ch_valid) begin
            ch_d[ch_sel] = {ch_q[ch_sel][WIDTH-2:0], ch_q[ch_sel][WIDTH-1]};
          end
        end
        MODE_CHAIN: begin
          ch_d[0] = {ch_q[0][WIDTH-2:0], ser_in};
          for (int i = 1; i < NUM_CH; i++) begin
            ch_d[i] = {ch_q[i][WIDTH-2:0], ch_q[i-1][WIDTH-1]};
          end
          for (int i = 0; i < NUM_CH; i++) begin
            fill_d[i] = sat_inc(fill_q[i]);
          end
        end
        MODE_CLEAR: begin
          if (ch_valid) begin
            ch_d[ch_sel]   = '0;
            fill_d[ch_sel] = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_sync_q <= '0;
      cap_sync_q   <= '0;
      shift_hist_q <= 1'b0;
      cap_hist_q   <= 1'b0;
      snap_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i]   <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      shift_sync_q <= {shift_sync_q[SYNC_STAGES-2:0], shift_strb};
      cap_sync_q   <= {cap_sync_q[SYNC_STAGES-2:0], cap_strb};
      shift_hist_q <= shift_sync_q[SYNC_STAGES-1];
      cap_hist_q   <= cap_sync_q[SYNC_STAGES-1];
      snap_q       <= snap_d;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i]   <= ch_d[i];
        fill_q[i] <= fill_d[i];
      end
    end
  end

  assign par_out = out_en ? snap_q : '0;
  assign ser_out = ch_q[NUM_CH-1][WIDTH-1];
  assign rd_full = rd_valid && (fill_q[rd_sel] == FILL_W'(WIDTH));

endmodule

// File: doc/multichannel_shift_bank.md
Name: multichannel_shift_bank

Overview:
- Parametrised successor to the 4x8 serial-entry shift register bank.
- Provides NUM_CH channels, each WIDTH bits wide, all on a single clock. Pin-driven strobes are synchronised and edge-detected instead of being used as gated clocks.
- Adds three functions: rotate, cascaded chain mode and per-channel fill tracking. Also provides a snapshot register with output gating and a chain serial output.
- Sits between the TT pin interface (ui_in / uo_out) and downstream logic.

Parameters:
- NUM_CH, 4, number of channels (≥2).
- WIDTH, 8, bits per channel (≥2).
- SYNC_STAGES, 2, synchroniser depth for the strobe inputs (≥2).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  action enable; when 0, strobe pulses are discarded.
- shift_strb  in  1  asynchronous strobe; its rising edge triggers the action selected by mode.
- cap_strb  in  1  asynchronous strobe; its rising edge triggers a snapshot capture.
- mode  in  2  00 SHIFT, 01 ROTATE, 10 CHAIN, 11 CLEAR.
- ch_sel  in  $clog2(NUM_CH)  target channel for SHIFT, ROTATE and CLEAR.
- rd_sel  in  $clog2(NUM_CH)  source channel for capture and for rd_full.
- ser_in  in  1  serial data bit.
- out_en  in  1  output gate for par_out.
- par_out  out  WIDTH  snapshot when out_en=1, else 0.
- ser_out  out  1  ch[NUM_CH-1][WIDTH-1] (MSB of the chain).
- rd_full  out  1  1 when fill[rd_sel] == WIDTH.

Behaviour:
- Reset:
  - rst_n=0 immediately clears all channels, fill counters, snapshot, synchroniser flops and edge-history flops.
  - par_out=0, ser_out=0, rd_full=0.
- Strobe path (identical for each strobe):
  - SYNC_STAGES-flop synchroniser, then a history flop.
  - pulse = sync_last & ~hist.
  - A strobe first sampled high at edge k produces its action at edge k+SYNC_STAGES. With the default of 2, that is 3 edges counting edge k.
  - A strobe high for ≥1 cycle produces exactly one pulse.
  - A strobe held high across reset release produces exactly one pulse.
- ena, mode, ch_sel, rd_sel and ser_in are sampled unsynchronised at the action edge. The driver holds them stable from strobe assertion until the action edge.
- Pulse with ena=0: no state change.
- Actions on a shift pulse, by mode:
  - SHIFT: ch[ch_sel] <= {ch[ch_sel][WIDTH-2:0], ser_in}. fill[ch_sel] increments, saturating at WIDTH.
  - ROTATE: ch[ch_sel] <= {ch[ch_sel][WIDTH-2:0], ch[ch_sel][WIDTH-1]}. fill unchanged.
  - CHAIN: all channels shift as one NUM_CH*WIDTH register. ch[0] LSB takes ser_in; ch[i] LSB takes ch[i-1] MSB. Every fill counter increments, saturating. ch_sel is ignored.
  - CLEAR: ch[ch_sel] <= 0; fill[ch_sel] <= 0.
- Capture pulse: snapshot <= ch[rd_sel].
- Shift and capture pulses on the same edge: snapshot takes the pre-update value of ch[rd_sel].
- Fill counters are $clog2(WIDTH+1) bits wide and never wrap.
- Outputs:
  - par_out and rd_full are combinational from registered state plus out_en/rd_sel.
  - ser_out is direct from register state.
- Out-of-range ch_sel or rd_sel (NUM_CH not a power of 2):
  - Actions targeting the channel are ignored.
  - Capture loads 0.
  - rd_full=0.
- Reset asserted mid-operation: aborts any pending pulse. No action is generated from synchroniser contents after reset.

Test Plan (defaults: NUM_CH=4, WIDTH=8, SYNC_STAGES=2):
1. Reset: assert rst_n=0 between edges -> par_out=0x00, ser_out=0, rd_full=0 with no clock edge required; release with all strobes low -> outputs remain 0.
2. Shift and capture:
   - Stimulus: mode=SHIFT, ch_sel=2; strobe in the bits 1,0,1,1,0,0,1,0 (1-cycle strobes, ≥4 cycles apart).
   - After 7 shifts: rd_sel=2 gives rd_full=0. After the 8th: rd_full=1.
   - Capture with out_en=1 -> par_out=0xB2. out_en=0 -> 0x00.
   - Strobe sampled at edge k -> snapshot visible after edge k+2.
3. Rotate: then ROTATE ch2 once and capture -> par_out=0x65, rd_full still 1. CLEAR ch2, capture -> 0x00, rd_full=0.
4. Chain:
   - Load ch0=0x80 via SHIFT (ser_in 1 then seven 0s); others 0.
   - CHAIN with ser_in=0: after 1 pulse, ch0=0x00 and ch1=0x01.
   - ser_out=0 through 23 pulses and becomes 1 after the 24th.
5. Simultaneous strobes: ch1=0x0F, rd_sel=1; assert shift_strb (SHIFT, ser_in=1) and cap_strb in the same cycle -> par_out=0x0F; a later capture -> 0x1F.
6. ena and reset:
   - Pulse with ena=0 -> no change to channels, fill or snapshot.
   - rst_n low one cycle after a strobe assertion -> no action after release; all state 0.
   - shift_strb held high across release -> exactly one SHIFT action.
